// File: rtl/weight_fetch_arbiter.sv
// Round-robin arbiter that lends the shared weight ROM to one neuron per burst.
// Optional macro WEIGHT_FETCH_STALL_CNT_EN builds the saturating backpressure counter.
module weight_fetch_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_base,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [ADDR_W-1:0]          rom_address,
  output logic                       rom_enable,
  input  logic [DATA_W-1:0]          rom_data,
  output logic [DATA_W-1:0]          w_data,
  output logic                       w_valid,
  output logic                       w_last,
  input  logic                       w_ready,
  output logic [15:0]                stall_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_idx_s;

  // Lowest-distance set request from the pointer wins; scanning backwards lets the nearest overwrite.
  always_comb begin : arb
    int idx;
    idx       = 0;
    win_idx_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        win_idx_s = IDX_W'(idx);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          addr_d  = req_base[int'(win_idx_s)*ADDR_W +: ADDR_W];
          cnt_d   = req_len[int'(win_idx_s)*LEN_W +: LEN_W];
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
          ptr_d   = (int'(win_idx_s) == NUM_REQ - 1) ? '0 : win_idx_s + 1'b1;
          state_d = (cnt_d != '0) ? S_STREAM : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        // w_valid is always high here, so w_ready alone completes a beat.
        if (w_ready) begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_STREAM;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rom_enable  = 1'b0;
    rom_address = '0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_data      = '0;
    done        = '0;
    case (state_q)
      S_STREAM: begin
        rom_enable  = 1'b1;
        rom_address = addr_q;
        w_valid     = 1'b1;
        w_last      = (cnt_q == LEN_W'(1));
        w_data      = rom_data;
      end
      S_DONE:  done = grant_q;
      default: done = '0;
    endcase
  end

  assign grant = grant_q;

`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else if (w_valid && !w_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Bench for weight_fetch_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a burst-level reference model.
module tb_weight_fetch_arbiter;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [15:0]   req_base, req_len;
  logic [N-1:0]  grant, done;
  logic [7:0]    rom_address, rom_data, w_data;
  logic          rom_enable, w_valid, w_last, w_ready;
  logic [15:0]   stall_cnt;
  logic [7:0]    rom [256];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  // 8'hEE stands in for the floating bus so any leak onto w_data is visible.
  assign rom_data = rom_enable ? rom[rom_address] : 8'hEE;

  weight_fetch_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_base(req_base), .req_len(req_len),
    .grant(grant), .done(done), .rom_address(rom_address), .rom_enable(rom_enable),
    .rom_data(rom_data), .w_data(w_data), .w_valid(w_valid), .w_last(w_last),
    .w_ready(w_ready), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] rq;
    logic [7:0] b0, l0, b1, l1;
    logic       rdy;
    logic [1:0] g, d;
    logic       v, l;
    logic [7:0] dat, ad;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] rq, logic [7:0] b0, logic [7:0] l0,
                              logic [7:0] b1, logic [7:0] l1, logic rdy, logic [1:0] g,
                              logic [1:0] d, logic v, logic l, logic [7:0] dat, logic [7:0] ad);
    vec_t r;
    r.rst = rst; r.rq = rq; r.b0 = b0; r.l0 = l0; r.b1 = b1; r.l1 = l1; r.rdy = rdy;
    r.g = g; r.d = d; r.v = v; r.l = l; r.dat = dat; r.ad = ad;
    return r;
  endfunction

  // Burst-level reference model state.
  int         m_owner, m_left, m_ptr, m_stall;
  bit         m_in_done;
  logic [7:0] m_addr;
  bit         want [N];
  logic [7:0] mb [N], ml [N];

  initial begin
    vec_t       tbl [23];
    logic [7:0] pat [4];
    logic [1:0] eg, ed;
    logic [15:0] exp_stall;
    bit         stream, rst_now, any;
    int         w;

    pat[0] = 8'd1; pat[1] = 8'd3; pat[2] = 8'd2; pat[3] = 8'd5;
    for (int i = 0; i < 256; i++) rom[i] = (i < 8) ? pat[i % 4] : (8'(i) ^ 8'h5A);

    // rst req b0 l0 b1 l1 rdy | grant done valid last data addr
    tbl[0]  = mk(1'b1, 2'b00, 8'h00, 8'd0, 8'h00, 8'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[1]  = mk(1'b0, 2'b01, 8'h00, 8'd4, 8'h00, 8'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[2]  = mk(1'b0, 2'b01, 8'h00, 8'd4, 8'h00, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'd1, 8'h00);
    tbl[3]  = mk(1'b0, 2'b01, 8'h40, 8'd9, 8'h00, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'd3, 8'h01);
    tbl[4]  = mk(1'b0, 2'b01, 8'h40, 8'd9, 8'h00, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'd2, 8'h02);
    tbl[5]  = mk(1'b0, 2'b01, 8'h40, 8'd9, 8'h00, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 8'd5, 8'h03);
    tbl[6]  = mk(1'b0, 2'b00, 8'h40, 8'd9, 8'h00, 8'd0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[7]  = mk(1'b0, 2'b11, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[8]  = mk(1'b0, 2'b11, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 8'd1, 8'h04);
    tbl[9]  = mk(1'b0, 2'b11, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 8'd3, 8'h05);
    tbl[10] = mk(1'b0, 2'b01, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[11] = mk(1'b0, 2'b01, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[12] = mk(1'b0, 2'b01, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'd1, 8'h00);
    tbl[13] = mk(1'b0, 2'b01, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 8'd3, 8'h01);
    tbl[14] = mk(1'b0, 2'b00, 8'h00, 8'd2, 8'h04, 8'd2, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[15] = mk(1'b0, 2'b10, 8'h00, 8'd2, 8'h00, 8'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[16] = mk(1'b0, 2'b10, 8'h00, 8'd2, 8'h00, 8'd0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[17] = mk(1'b0, 2'b00, 8'h00, 8'd2, 8'h00, 8'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[18] = mk(1'b0, 2'b01, 8'hFF, 8'd2, 8'h00, 8'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[19] = mk(1'b0, 2'b01, 8'hFF, 8'd2, 8'h00, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'hA5, 8'hFF);
    tbl[20] = mk(1'b0, 2'b01, 8'hFF, 8'd2, 8'h00, 8'd0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 8'd1, 8'h00);
    tbl[21] = mk(1'b0, 2'b00, 8'hFF, 8'd2, 8'h00, 8'd0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'd0, 8'h00);
    tbl[22] = mk(1'b0, 2'b00, 8'hFF, 8'd2, 8'h00, 8'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'h00);

    reset = 1'b1; req = '0; req_base = 16'h0; req_len = 16'h0; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst; req = tbl[i].rq; w_ready = tbl[i].rdy;
      req_base = {tbl[i].b1, tbl[i].b0}; req_len = {tbl[i].l1, tbl[i].l0};
      #1;
      chk($sformatf("tbl%0d grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d done", i), done, tbl[i].d);
      chk($sformatf("tbl%0d w_valid", i), w_valid, tbl[i].v);
      chk($sformatf("tbl%0d rom_enable", i), rom_enable, tbl[i].v);
      chk($sformatf("tbl%0d w_last", i), w_last, tbl[i].l);
      chk($sformatf("tbl%0d w_data", i), w_data, tbl[i].dat);
      if (tbl[i].v) chk($sformatf("tbl%0d rom_address", i), rom_address, tbl[i].ad);
      tick();
    end

    // Backpressure: base 2, len 3, first beat held for three cycles.
    reset = 1'b1; req = '0; tick(); reset = 1'b0;
    req = 2'b01; req_base = 16'h0002; req_len = 16'h0003; w_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall hold data", w_data, 8'd2);
      chk("stall hold addr", rom_address, 8'h02);
      chk("stall hold valid", w_valid, 1'b1);
      tick();
    end
    w_ready = 1'b1; #1;
    chk("stall beat1", w_data, 8'd2);
    tick(); #1;
    chk("stall beat2", w_data, 8'd5);
    chk("stall beat2 addr", rom_address, 8'h03);
    tick(); #1;
    chk("stall beat3", w_data, 8'd1);
    chk("stall beat3 last", w_last, 1'b1);
    tick(); #1;
    chk("stall done", done, 2'b01);
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 16'd3);
`else
    chk("stall_cnt", stall_cnt, 16'd0);
`endif
    req = 2'b00; tick();

    // Reset after two of four beats, then a fresh double request restarts at requester 0.
    req = 2'b01; req_base = 16'h0000; req_len = 16'h0004; w_ready = 1'b1;
    tick(); tick(); tick();
    #1; chk("pre-reset beat3", w_data, 8'd2);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("rst grant", grant, 2'b00);
    chk("rst w_valid", w_valid, 1'b0);
    chk("rst rom_enable", rom_enable, 1'b0);
    chk("rst done", done, 2'b00);
    req = 2'b11; req_base = 16'h0106; req_len = 16'h0101;
    tick(); #1;
    chk("rst no done", done, 2'b00);
    chk("rst new grant", grant, 2'b01);
    chk("rst new data", w_data, 8'd2);
    chk("rst new last", w_last, 1'b1);
    tick(); #1;
    chk("rst new done", done, 2'b01);
    req = 2'b10; tick(); tick(); #1;
    chk("rst second grant", grant, 2'b10);
    chk("rst second data", w_data, 8'd3);
    tick(); req = 2'b00; tick();

    // Randomized traffic against the reference model.
    reset = 1'b1; tick(); reset = 1'b0;
    m_owner = -1; m_left = 0; m_ptr = 0; m_stall = 0; m_in_done = 1'b0; m_addr = 8'h00;
    for (int i = 0; i < N; i++) begin want[i] = 1'b0; mb[i] = 8'h00; ml[i] = 8'h00; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_now = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i] = 1'b1; mb[i] = 8'($urandom); ml[i] = 8'($urandom_range(0, 5));
        end
        if (m_owner == i) begin
          req_base[i*8 +: 8] = 8'($urandom);
          req_len[i*8 +: 8]  = 8'($urandom);
          req[i] = want[i] && ($urandom_range(0, 1) == 0);
        end else begin
          req_base[i*8 +: 8] = mb[i];
          req_len[i*8 +: 8]  = ml[i];
          req[i] = want[i];
        end
      end
      w_ready = ($urandom_range(0, 2) != 0);
      reset = rst_now;
      #1;
      stream = (m_owner >= 0) && !m_in_done;
      eg = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
      ed = (m_owner >= 0 && m_in_done) ? (2'b01 << m_owner) : 2'b00;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
      exp_stall = 16'(m_stall);
`else
      exp_stall = 16'h0000;
`endif
      chk("rnd grant", grant, eg);
      chk("rnd done", done, ed);
      chk("rnd w_valid", w_valid, stream);
      chk("rnd rom_enable", rom_enable, stream);
      chk("rnd w_last", w_last, stream && (m_left == 1));
      chk("rnd w_data", w_data, stream ? rom[m_addr] : 8'h00);
      if (stream) chk("rnd rom_address", rom_address, m_addr);
      chk("rnd stall_cnt", stall_cnt, exp_stall);
      if (m_owner >= 0 && m_in_done) want[m_owner] = 1'b0;

      if (rst_now) begin
        m_owner = -1; m_left = 0; m_ptr = 0; m_stall = 0; m_in_done = 1'b0;
      end else begin
        if (stream && !w_ready && m_stall < 65535) m_stall++;
        if (m_owner < 0) begin
          any = 1'b0; w = 0;
          for (int k = 0; k < N; k++) begin
            if (!any && req[(m_ptr + k) % N]) begin any = 1'b1; w = (m_ptr + k) % N; end
          end
          if (any) begin
            m_owner = w; m_addr = mb[w]; m_left = int'(ml[w]);
            m_in_done = (ml[w] == 8'd0); m_ptr = (w + 1) % N;
          end
        end else if (m_in_done) begin
          m_owner = -1; m_in_done = 1'b0;
        end else if (w_ready) begin
          m_addr = m_addr + 8'd1; m_left--;
          if (m_left == 0) m_in_done = 1'b1;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
